riscv_mc_control: RTL and testbench

Multi-cycle control unit for the RISC-V core: a state machine that sequences fetch, decode, execute, memory and writeback for RV32I-style instructions, replacing the single-cycle combinational decoder. It sits between the register file/ALU datapath and the instruction/data memory ports. It holds per-instruction control in registers and adds memory handshakes, a full branch-compare set, illegal-instruction and timeout traps, and a retire pulse.

---
 rtl/riscv_mc_control_pkg.sv | 113 +++++++++++
 rtl/riscv_mc_control_if.sv | 30 +++
 rtl/riscv_mc_control_branch_cmp.sv | 32 +++
 rtl/riscv_mc_control.sv | 262 ++++++++++++++++++++++++++
 tb/tb_riscv_mc_control.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mc_control_pkg.sv
// riscv_ctrl_pkg: shared constants and types for the multi-cycle control unit.
//   - RV32I opcode / funct3 / funct7 constants
//   - ALU operation enum, FSM state enum, instruction class enum
//   - pc_sel, wb_sel, op2sel, mem_val encodings and trap-cause codes
//   - small decode helpers used by the DECODE state
package riscv_ctrl_pkg;

    // Opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_SLTU  = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_AND   = 5'd9,
        ALU_COPY2 = 5'd10   // pass operand 2 through (LUI)
    } alufun_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR
    } iclass_t;

    localparam logic [2:0] PC_PLUS4  = 3'd0;
    localparam logic [2:0] PC_JALR   = 3'd1;
    localparam logic [2:0] PC_JAL    = 3'd2;
    localparam logic [2:0] PC_BRANCH = 3'd3;
    localparam logic [2:0] PC_TRAP   = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] OP2_RS2  = 2'd0;
    localparam logic [1:0] OP2_IIMM = 2'd1;
    localparam logic [1:0] OP2_SIMM = 2'd2;
    localparam logic [1:0] OP2_UIMM = 2'd3;

    localparam logic [1:0] MV_WORD = 2'd0;
    localparam logic [1:0] MV_HALF = 2'd1;
    localparam logic [1:0] MV_BYTE = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM    = 2'd2;
    localparam logic [1:0] CAUSE_DMEM    = 2'd3;

    // funct7[5] selects SUB only for register-register ops; for shifts it
    // selects arithmetic right shift in both R and I forms.
    function automatic alufun_t alu_decode(input logic [2:0] f3,
                                           input logic f7b5,
                                           input logic is_reg);
        case (f3)
            F3_ADD:  alu_decode = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_decode = ALU_SLL;
            F3_SLT:  alu_decode = ALU_SLT;
            F3_SLTU: alu_decode = ALU_SLTU;
            F3_XOR:  alu_decode = ALU_XOR;
            F3_SR:   alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_decode = ALU_OR;
            default: alu_decode = ALU_AND;
        endcase
    endfunction

    // Access size from funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic [1:0] mem_val_of(input logic [1:0] f3lo);
        case (f3lo)
            2'b00:   mem_val_of = MV_BYTE;
            2'b01:   mem_val_of = MV_HALF;
            default: mem_val_of = MV_WORD;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_control_if.sv
// riscv_mc_control_if: instruction and data memory handshake bundle.
//   inst      instruction word, valid while imem_ack=1
//   imem_req  fetch request (control -> memory), held until imem_ack
//   imem_ack  fetch acknowledge (memory -> control)
//   dmem_req  data request, held until dmem_ack
//   dmem_ack  data acknowledge
//   mem_rw    1 = store, 0 = load
//   mem_val   access size: 0 word, 1 half, 2 byte
// Handshake: a request rises and stays high until the cycle in which the
// matching ack is seen high; the transfer completes in that cycle. An ack
// while the request is low is ignored.
interface riscv_mc_control_if;
    logic [31:0] inst;
    logic        imem_req;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_ack;
    logic        mem_rw;
    logic [1:0]  mem_val;

    modport master (
        input  inst, imem_ack, dmem_ack,
        output imem_req, dmem_req, mem_rw, mem_val
    );

    modport slave (
        output inst, imem_ack, dmem_ack,
        input  imem_req, dmem_req, mem_rw, mem_val
    );
endinterface

// File: rtl/riscv_mc_control_branch_cmp.sv
// riscv_branch_cmp: branch condition evaluation.
//   rs1, rs2  XLEN operands
//   funct3    branch type from the instruction
//   taken     1 when the branch condition holds
// With BRANCH_FULL=0 only BEQ/BNE can be taken; the ordered compares are
// rejected as illegal earlier, in decode.
module riscv_branch_cmp
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BRANCH_FULL = 1
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken
);
    localparam bit FULL = (BRANCH_FULL != 0);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = FULL && ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = FULL && ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = FULL && (rs1 <  rs2);
            F3_BGEU: taken = FULL && (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multi-cycle RV32I control FSM.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          memory handshake bundle (master side)
//   rs1, rs2     register-file read data for branch compare
//   ir_we        instruction-register load strobe (FETCH ack cycle)
//   pc_we/pc_sel PC update strobe and source select
//   alufun, op1sel, op2sel, wb_sel   registered datapath control
//   rf_wen       register write strobe (WB, rd != 0)
//   retire       one pulse per completed instruction
//   trap         one pulse on trap entry; trap_cause held until next trap
//   dbg_state    current FSM state
// Sequence: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH.
// Datapath selects are registers loaded at the end of DECODE; strobes and
// requests are decoded from the state register (plus the ack where a
// transfer completes), so each strobe is high for exactly one cycle and
// every output drops immediately when rst_n asserts.
module riscv_mc_control
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 0,
    parameter int BRANCH_FULL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    riscv_mc_control_if.master  bus,
    input  logic [XLEN-1:0]     rs1,
    input  logic [XLEN-1:0]     rs2,
    output logic                ir_we,
    output logic                pc_we,
    output logic [2:0]          pc_sel,
    output alufun_t             alufun,
    output logic                op1sel,
    output logic [1:0]          op2sel,
    output logic [1:0]          wb_sel,
    output logic                rf_wen,
    output logic                retire,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output state_t              dbg_state
);
    state_t      state;
    iclass_t     cls;
    logic [31:0] ir;
    logic [4:0]  rd;
    logic        mem_rw_q;
    logic [1:0]  mem_val_q;
    logic [31:0] wait_cnt;
    logic        taken;
    logic        timeout_hit;

    // Register-source fields are consumed by the datapath, not here.
    wire unused_ir = ^ir[24:15];

    wire [6:0] opc = ir[6:0];
    wire [2:0] f3  = ir[14:12];
    wire [6:0] f7  = ir[31:25];

    // Last allowed waiting cycle: an ack in this cycle still completes.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == 32'(MEM_TIMEOUT - 1));

    riscv_branch_cmp #(.XLEN(XLEN), .BRANCH_FULL(BRANCH_FULL)) u_cmp (
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (f3),
        .taken  (taken)
    );

    // Combinational decode of the latched instruction, captured in DECODE.
    logic       d_legal;
    iclass_t    d_cls;
    alufun_t    d_alu;
    logic       d_op1;
    logic [1:0] d_op2;
    logic [1:0] d_wb;
    logic [1:0] d_mval;
    logic       d_rw;

    always_comb begin
        d_legal = 1'b1;
        d_cls   = CL_ALU;
        d_alu   = ALU_ADD;
        d_op1   = 1'b0;
        d_op2   = OP2_RS2;
        d_wb    = WB_ALU;
        d_mval  = MV_WORD;
        d_rw    = 1'b0;
        case (opc)
            OP_REG: begin
                d_alu = alu_decode(f3, f7[5], 1'b1);
                if (!(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))))
                    d_legal = 1'b0;
            end
            OP_IMM: begin
                d_op2 = OP2_IIMM;
                d_alu = alu_decode(f3, f7[5], 1'b0);
                if (f3 == F3_SLL && f7 != F7_BASE)
                    d_legal = 1'b0;
                if (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT)
                    d_legal = 1'b0;
            end
            OP_LUI: begin
                d_op2 = OP2_UIMM;
                d_alu = ALU_COPY2;
            end
            OP_AUIPC: begin
                d_op1 = 1'b1;
                d_op2 = OP2_UIMM;
            end
            OP_JAL: begin
                d_cls = CL_JAL;
                d_op1 = 1'b1;
                d_wb  = WB_PC4;
            end
            OP_JALR: begin
                d_cls = CL_JALR;
                d_op2 = OP2_IIMM;
                d_wb  = WB_PC4;
                if (f3 != 3'b000)
                    d_legal = 1'b0;
            end
            OP_LOAD: begin
                d_cls  = CL_LOAD;
                d_op2  = OP2_IIMM;
                d_wb   = WB_MEM;
                d_mval = mem_val_of(f3[1:0]);
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
                    d_legal = 1'b0;
            end
            OP_STORE: begin
                d_cls  = CL_STORE;
                d_op2  = OP2_SIMM;
                d_rw   = 1'b1;
                d_mval = mem_val_of(f3[1:0]);
                if (f3[2] || f3 == 3'b011)
                    d_legal = 1'b0;
            end
            OP_BRANCH: begin
                d_cls = CL_BRANCH;
                d_alu = ALU_SUB;
                if (f3[2:1] == 2'b01 || (f3[2] && BRANCH_FULL == 0))
                    d_legal = 1'b0;
            end
            default: d_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cls        <= CL_ALU;
            ir         <= '0;
            rd         <= '0;
            alufun     <= ALU_ADD;
            op1sel     <= 1'b0;
            op2sel     <= '0;
            wb_sel     <= '0;
            mem_rw_q   <= 1'b0;
            mem_val_q  <= '0;
            trap_cause <= CAUSE_NONE;
            wait_cnt   <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        ir    <= bus.inst;
                        state <= ST_DECODE;
                    end else if (timeout_hit) begin
                        trap_cause <= CAUSE_IMEM;
                        state      <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                ST_DECODE: begin
                    if (!d_legal) begin
                        trap_cause <= CAUSE_ILLEGAL;
                        state      <= ST_TRAP;
                    end else begin
                        cls       <= d_cls;
                        rd        <= ir[11:7];
                        alufun    <= d_alu;
                        op1sel    <= d_op1;
                        op2sel    <= d_op2;
                        wb_sel    <= d_wb;
                        mem_rw_q  <= d_rw;
                        mem_val_q <= d_mval;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (cls)
                        CL_LOAD, CL_STORE: state <= ST_MEM;
                        CL_BRANCH:         state <= ST_FETCH;
                        default:           state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (bus.dmem_ack) begin
                        state <= (cls == CL_STORE) ? ST_FETCH : ST_WB;
                    end else if (timeout_hit) begin
                        trap_cause <= CAUSE_DMEM;
                        state      <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                ST_TRAP: state <= ST_FETCH;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_we  = 1'b0;
        pc_sel = PC_PLUS4;
        retire = 1'b0;
        rf_wen = 1'b0;
        trap   = 1'b0;
        case (state)
            ST_EXEC: begin
                if (cls == CL_BRANCH) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    pc_sel = taken ? PC_BRANCH : PC_PLUS4;
                end
            end
            ST_MEM: begin
                if (bus.dmem_ack && cls == CL_STORE) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            ST_WB: begin
                pc_we  = 1'b1;
                retire = 1'b1;
                rf_wen = (rd != 5'd0);
                if (cls == CL_JAL)
                    pc_sel = PC_JAL;
                else if (cls == CL_JALR)
                    pc_sel = PC_JALR;
            end
            ST_TRAP: begin
                pc_we  = 1'b1;
                pc_sel = PC_TRAP;
                trap   = 1'b1;
            end
            default: ;
        endcase
    end

    assign ir_we        = (state == ST_FETCH) && bus.imem_ack;
    assign bus.imem_req = (state == ST_FETCH);
    assign bus.dmem_req = (state == ST_MEM);
    assign bus.mem_rw   = mem_rw_q;
    assign bus.mem_val  = mem_val_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed bench for riscv_mc_control (MEM_TIMEOUT=4, BRANCH_FULL=1).
// Cycle numbers in step names count from the first FETCH cycle (= 1).
module tb_riscv_mc_control;
    import riscv_ctrl_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_mc_control_if bus();
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        ir_we, pc_we, op1sel, rf_wen, retire, trap;
    logic [2:0]  pc_sel;
    logic [1:0]  op2sel, wb_sel, trap_cause;
    alufun_t     alufun;
    state_t      dbg_state;

    int n_vec = 0;
    int n_err = 0;

    riscv_mc_control #(.XLEN(32), .MEM_TIMEOUT(4), .BRANCH_FULL(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .rs1        (rs1),
        .rs2        (rs2),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .alufun     (alufun),
        .op1sel     (op1sel),
        .op2sel     (op2sel),
        .wb_sel     (wb_sel),
        .rf_wen     (rf_wen),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause),
        .dbg_state  (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle, apply acks for the new cycle, settle before sampling.
    task automatic cyc(input logic ia, input logic da);
        @(posedge clk);
        #1;
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " state"},  32'(dbg_state), 32'(ST_IDLE));
        chk({tag, " ireq"},   32'(bus.imem_req), 32'd0);
        chk({tag, " dreq"},   32'(bus.dmem_req), 32'd0);
        chk({tag, " rw"},     32'(bus.mem_rw), 32'd0);
        chk({tag, " mval"},   32'(bus.mem_val), 32'd0);
        chk({tag, " ir_we"},  32'(ir_we), 32'd0);
        chk({tag, " pc_we"},  32'(pc_we), 32'd0);
        chk({tag, " pc_sel"}, 32'(pc_sel), 32'd0);
        chk({tag, " alufun"}, 32'(alufun), 32'd0);
        chk({tag, " op1sel"}, 32'(op1sel), 32'd0);
        chk({tag, " op2sel"}, 32'(op2sel), 32'd0);
        chk({tag, " wb_sel"}, 32'(wb_sel), 32'd0);
        chk({tag, " rf_wen"}, 32'(rf_wen), 32'd0);
        chk({tag, " retire"}, 32'(retire), 32'd0);
        chk({tag, " trap"},   32'(trap), 32'd0);
        chk({tag, " cause"},  32'(trap_cause), 32'd0);
    endtask

    // ADD x3,x1,x2 with zero-wait fetch: retire in cycle 4.
    task automatic run_add(input string tag);
        bus.inst = 32'h002081B3;
        cyc(1'b1, 1'b0);
        chk({tag, " c1 state"}, 32'(dbg_state), 32'(ST_FETCH));
        chk({tag, " c1 ir_we"}, 32'(ir_we), 32'd1);
        cyc(1'b0, 1'b0);
        chk({tag, " c2 state"}, 32'(dbg_state), 32'(ST_DECODE));
        chk({tag, " c2 ir_we"}, 32'(ir_we), 32'd0);
        cyc(1'b0, 1'b0);
        chk({tag, " c3 retire"}, 32'(retire), 32'd0);
        chk({tag, " c3 alufun"}, 32'(alufun), 32'(ALU_ADD));
        chk({tag, " c3 op2sel"}, 32'(op2sel), 32'(OP2_RS2));
        cyc(1'b0, 1'b0);
        chk({tag, " c4 rf_wen"}, 32'(rf_wen), 32'd1);
        chk({tag, " c4 pc_we"},  32'(pc_we), 32'd1);
        chk({tag, " c4 retire"}, 32'(retire), 32'd1);
        chk({tag, " c4 pc_sel"}, 32'(pc_sel), 32'd0);
        chk({tag, " c4 wb_sel"}, 32'(wb_sel), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inst     = '0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ADD
        run_add("add");

        // 2: BLTU 0xFFFFFFFF < 1 unsigned -> not taken
        rs1 = 32'hFFFF_FFFF;
        rs2 = 32'h0000_0001;
        bus.inst = 32'h0020E463;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("bltu c3 retire", 32'(retire), 32'd1);
        chk("bltu c3 pc_we",  32'(pc_we), 32'd1);
        chk("bltu c3 pc_sel", 32'(pc_sel), 32'(PC_PLUS4));
        chk("bltu c3 rf_wen", 32'(rf_wen), 32'd0);

        // 3: BLT -1 < 1 signed -> taken
        bus.inst = 32'h0020C463;
        cyc(1'b1, 1'b0);
        chk("blt c1 state", 32'(dbg_state), 32'(ST_FETCH));
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("blt c3 retire", 32'(retire), 32'd1);
        chk("blt c3 pc_sel", 32'(pc_sel), 32'(PC_BRANCH));

        // 4: LW x5,0(x1) with dmem ack on the 4th MEM cycle
        bus.inst = 32'h0000A283;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("lw c3 op2sel", 32'(op2sel), 32'(OP2_IIMM));
        chk("lw c3 dreq",   32'(bus.dmem_req), 32'd0);
        for (int c = 4; c <= 6; c++) begin
            cyc(1'b0, 1'b0);
            chk($sformatf("lw c%0d dreq", c),   32'(bus.dmem_req), 32'd1);
            chk($sformatf("lw c%0d retire", c), 32'(retire), 32'd0);
        end
        cyc(1'b0, 1'b1);
        chk("lw c7 dreq",  32'(bus.dmem_req), 32'd1);
        chk("lw c7 rw",    32'(bus.mem_rw), 32'd0);
        chk("lw c7 mval",  32'(bus.mem_val), 32'(MV_WORD));
        chk("lw c7 pc_we", 32'(pc_we), 32'd0);
        chk("lw c7 trap",  32'(trap), 32'd0);
        cyc(1'b0, 1'b0);
        chk("lw c8 dreq",   32'(bus.dmem_req), 32'd0);
        chk("lw c8 wb_sel", 32'(wb_sel), 32'(WB_MEM));
        chk("lw c8 rf_wen", 32'(rf_wen), 32'd1);
        chk("lw c8 retire", 32'(retire), 32'd1);

        // 5: SB x2,0(x1), zero wait -> retire in cycle 4 in MEM
        bus.inst = 32'h00208023;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("sb c3 op2sel", 32'(op2sel), 32'(OP2_SIMM));
        cyc(1'b0, 1'b1);
        chk("sb c4 dreq",   32'(bus.dmem_req), 32'd1);
        chk("sb c4 rw",     32'(bus.mem_rw), 32'd1);
        chk("sb c4 mval",   32'(bus.mem_val), 32'(MV_BYTE));
        chk("sb c4 retire", 32'(retire), 32'd1);
        chk("sb c4 pc_we",  32'(pc_we), 32'd1);
        chk("sb c4 rf_wen", 32'(rf_wen), 32'd0);
        cyc(1'b0, 1'b0);
        chk("sb c5 state",  32'(dbg_state), 32'(ST_FETCH));
        chk("sb c5 retire", 32'(retire), 32'd0);

        // 6: illegal opcode 0x7F -> trap cause 1 in cycle 3
        bus.inst = 32'h0000007F;
        cyc(1'b0, 1'b0);
        bus.dmem_ack = 1'b0;
        bus.imem_ack = 1'b1;
        #1;
        cyc(1'b0, 1'b0);
        chk("ill c2 trap", 32'(trap), 32'd0);
        cyc(1'b0, 1'b0);
        chk("ill c3 trap",   32'(trap), 32'd1);
        chk("ill c3 cause",  32'(trap_cause), 32'(CAUSE_ILLEGAL));
        chk("ill c3 pc_sel", 32'(pc_sel), 32'(PC_TRAP));
        chk("ill c3 pc_we",  32'(pc_we), 32'd1);
        chk("ill c3 rf_wen", 32'(rf_wen), 32'd0);
        chk("ill c3 retire", 32'(retire), 32'd0);
        chk("ill c3 dreq",   32'(bus.dmem_req), 32'd0);

        // 7: ADDI x0,x0,5 -> retire without register write
        bus.inst = 32'h00500013;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("addi0 c4 retire", 32'(retire), 32'd1);
        chk("addi0 c4 rf_wen", 32'(rf_wen), 32'd0);
        chk("addi0 c4 pc_we",  32'(pc_we), 32'd1);

        // 8: JAL x1 -> pc_sel=2, wb_sel=2; trap_cause still held
        bus.inst = 32'h000000EF;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("jal c3 op1sel", 32'(op1sel), 32'd1);
        cyc(1'b0, 1'b0);
        chk("jal c4 pc_sel", 32'(pc_sel), 32'(PC_JAL));
        chk("jal c4 wb_sel", 32'(wb_sel), 32'(WB_PC4));
        chk("jal c4 rf_wen", 32'(rf_wen), 32'd1);
        chk("jal c4 cause",  32'(trap_cause), 32'(CAUSE_ILLEGAL));

        // 9: imem never acks -> 4 waiting cycles, trap cause 2 in cycle 5
        for (int c = 1; c <= 4; c++) begin
            cyc(1'b0, 1'b0);
            chk($sformatf("ito c%0d ireq", c), 32'(bus.imem_req), 32'd1);
            chk($sformatf("ito c%0d trap", c), 32'(trap), 32'd0);
        end
        cyc(1'b0, 1'b0);
        chk("ito c5 trap",   32'(trap), 32'd1);
        chk("ito c5 cause",  32'(trap_cause), 32'(CAUSE_IMEM));
        chk("ito c5 ireq",   32'(bus.imem_req), 32'd0);
        chk("ito c5 pc_sel", 32'(pc_sel), 32'(PC_TRAP));
        chk("ito c5 retire", 32'(retire), 32'd0);

        // 10: ack on the 4th FETCH cycle wins over the limit
        bus.inst = 32'h002081B3;
        for (int c = 1; c <= 3; c++) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("ack4 c4 ir_we", 32'(ir_we), 32'd1);
        cyc(1'b0, 1'b0);
        chk("ack4 c5 state", 32'(dbg_state), 32'(ST_DECODE));
        chk("ack4 c5 trap",  32'(trap), 32'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("ack4 c7 retire", 32'(retire), 32'd1);
        chk("ack4 c7 cause",  32'(trap_cause), 32'(CAUSE_IMEM));

        // 11: LW with dmem never acking -> trap cause 3 in cycle 8
        bus.inst = 32'h0000A283;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        for (int c = 4; c <= 7; c++) cyc(1'b0, 1'b0);
        chk("dto c7 dreq", 32'(bus.dmem_req), 32'd1);
        cyc(1'b0, 1'b0);
        chk("dto c8 trap",   32'(trap), 32'd1);
        chk("dto c8 cause",  32'(trap_cause), 32'(CAUSE_DMEM));
        chk("dto c8 dreq",   32'(bus.dmem_req), 32'd0);
        chk("dto c8 rf_wen", 32'(rf_wen), 32'd0);
        chk("dto c8 retire", 32'(retire), 32'd0);

        // 12: reset asserted while a store waits in MEM
        bus.inst = 32'h00208023;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("rst c4 dreq", 32'(bus.dmem_req), 32'd1);
        chk("rst c4 rw",   32'(bus.mem_rw), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_add("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
